voice_param_writer: RTL and testbench

Staging register bank and commit sequencer that writes operator parameters into the synth voices. Sits between the host command decoder (SPI/UART front end) and the array of `voice` instances. It accepts addressed 32-bit words, assembles one complete `VC_PARAM` image and drives it onto the shared `vc` bus. It then pulses the per-voice `select` lines so the chosen voices latch the image atomically.

---
 rtl/harbinger_pkg.sv | 45 ++++
 rtl/voice_param_writer_if.sv | 28 ++
 rtl/vpw_addr_decode.sv | 39 +++
 rtl/voice_param_writer.sv | 112 +++++++++++
 tb/tb_voice_param_writer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/harbinger_pkg.sv
// Shared voice-parameter definitions: VC_PARAM image layout, field codes and the writer FSM states.
// Used by both the parameter writer and the voice instances.
package harbinger_pkg;

  localparam int NUM_OPS    = 6;
  localparam int NUM_FIELDS = 11;  // fields 0..10 carry parameter data

  localparam logic [3:0] FLD_FREQ      = 4'd0;
  localparam logic [3:0] FLD_AT_TIME   = 4'd1;
  localparam logic [3:0] FLD_AT_INC    = 4'd2;
  localparam logic [3:0] FLD_DE_TIME   = 4'd3;
  localparam logic [3:0] FLD_DE_INC    = 4'd4;
  localparam logic [3:0] FLD_SU_TIME   = 4'd5;
  localparam logic [3:0] FLD_SU_LVL    = 4'd6;
  localparam logic [3:0] FLD_RE_TIME   = 4'd7;
  localparam logic [3:0] FLD_RE_INC    = 4'd8;
  localparam logic [3:0] FLD_AMPLITUDE = 4'd9;
  localparam logic [3:0] FLD_MODIN     = 4'd10;
  localparam logic [3:0] FLD_CLEAR     = 4'd14;
  localparam logic [3:0] FLD_COMMIT    = 4'd15;

  typedef logic [NUM_OPS-1:0][31:0] op_word_t;

  typedef struct packed {
    op_word_t    freq;
    op_word_t    at_time;
    op_word_t    at_inc;
    op_word_t    de_time;
    op_word_t    de_inc;
    op_word_t    su_time;
    op_word_t    su_lvl;
    op_word_t    re_time;
    op_word_t    re_inc;
    op_word_t    amplitude;
    logic [31:0] modin_1;
    logic [31:0] modin_2;
  } VC_PARAM;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_DONE   = 2'd2
  } vpw_state_t;

endpackage

// File: rtl/voice_param_writer_if.sv
// Host write channel plus the staging image / select strobes fanned out to the voices.
// master = command source side, slave = voice_param_writer.
interface voice_param_writer_if #(
  parameter int NUM_VOICES = 8
);
  import harbinger_pkg::*;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [6:0]            wr_addr;
  logic [31:0]           wr_data;
  VC_PARAM               vc;
  logic [NUM_VOICES-1:0] select;
  logic                  commit_done;
  logic                  addr_err;
  logic [7:0]            word_cnt;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready, vc, select, commit_done, addr_err, word_cnt
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready, vc, select, commit_done, addr_err, word_cnt
  );

endinterface

// File: rtl/vpw_addr_decode.sv
// Combinational decode of a {field, op} command address into write enables and command flags.
// Zero latency; no handshake of its own.
module vpw_addr_decode
  import harbinger_pkg::*;
(
  input  logic [6:0]            addr,
  output logic [NUM_FIELDS-1:0] field_we,
  output logic [2:0]            op,
  output logic                  is_clear,
  output logic                  is_commit,
  output logic                  illegal
);

  logic [3:0] field;

  assign field = addr[6:3];
  assign op    = addr[2:0];

  always_comb begin
    field_we  = '0;
    is_clear  = 1'b0;
    is_commit = 1'b0;
    illegal   = 1'b0;
    if (field <= FLD_AMPLITUDE) begin
      if (op < 3'(NUM_OPS)) field_we[field] = 1'b1;
      else                  illegal         = 1'b1;
    end else if (field == FLD_MODIN) begin
      if (op <= 3'd1) field_we[FLD_MODIN] = 1'b1;
      else            illegal             = 1'b1;
    end else if (field == FLD_CLEAR) begin
      is_clear = 1'b1;
    end else if (field == FLD_COMMIT) begin
      is_commit = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/voice_param_writer.sv
// Stages addressed words into one VC_PARAM image and strobes it into the selected voices.
// Writes land one cycle after transfer; a COMMIT holds wr_ready low for the STROBE and DONE cycles.
module voice_param_writer
  import harbinger_pkg::*;
#(
  parameter int NUM_VOICES = 8
) (
  input  logic                 clk147,
  input  logic                 rst_n,
  voice_param_writer_if.slave  bus
);

  vpw_state_t            state_q, state_d;
  VC_PARAM               vc_q;
  logic [7:0]            cnt_q;
  logic                  rdy_q;
  logic                  err_q;
  logic [NUM_VOICES-1:0] mask_q;
  logic [NUM_VOICES-1:0] sel;
  logic                  done;
  logic                  fire;

  logic [NUM_FIELDS-1:0] field_we;
  logic [2:0]            op;
  logic                  is_clear;
  logic                  is_commit;
  logic                  illegal;

  vpw_addr_decode u_dec (
    .addr      (bus.wr_addr),
    .field_we  (field_we),
    .op        (op),
    .is_clear  (is_clear),
    .is_commit (is_commit),
    .illegal   (illegal)
  );

  // wr_ready is only ever high in IDLE, so every transfer happens there
  assign fire = bus.wr_valid && rdy_q;

  always_ff @(posedge clk147) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    sel     = '0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fire && is_commit) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        sel     = mask_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk147) begin
    if (!rst_n) begin
      vc_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      mask_q <= '0;
    end else begin
      err_q <= fire && illegal;
      if (fire && is_commit) mask_q <= bus.wr_data[NUM_VOICES-1:0];

      if (state_q == ST_DONE || (fire && is_clear)) cnt_q <= '0;
      else if (fire && (|field_we) && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;

      if (fire && is_clear) begin
        vc_q <= '0;
      end else if (fire) begin
        if (field_we[FLD_FREQ])      vc_q.freq[op]      <= bus.wr_data;
        if (field_we[FLD_AT_TIME])   vc_q.at_time[op]   <= bus.wr_data;
        if (field_we[FLD_AT_INC])    vc_q.at_inc[op]    <= bus.wr_data;
        if (field_we[FLD_DE_TIME])   vc_q.de_time[op]   <= bus.wr_data;
        if (field_we[FLD_DE_INC])    vc_q.de_inc[op]    <= bus.wr_data;
        if (field_we[FLD_SU_TIME])   vc_q.su_time[op]   <= bus.wr_data;
        if (field_we[FLD_SU_LVL])    vc_q.su_lvl[op]    <= bus.wr_data;
        if (field_we[FLD_RE_TIME])   vc_q.re_time[op]   <= bus.wr_data;
        if (field_we[FLD_RE_INC])    vc_q.re_inc[op]    <= bus.wr_data;
        if (field_we[FLD_AMPLITUDE]) vc_q.amplitude[op] <= bus.wr_data;
        if (field_we[FLD_MODIN]) begin
          if (op == 3'd0) vc_q.modin_1 <= bus.wr_data;
          else            vc_q.modin_2 <= bus.wr_data;
        end
      end
    end
  end

  assign bus.wr_ready    = rdy_q;
  assign bus.vc          = vc_q;
  assign bus.select      = sel;
  assign bus.commit_done = done;
  assign bus.addr_err    = err_q;
  assign bus.word_cnt    = cnt_q;

endmodule

// File: tb/tb_voice_param_writer.sv
// Bench for voice_param_writer: vector table for decode/writes, scoreboarded commits, voice latch model.
module tb_voice_param_writer;
  import harbinger_pkg::*;

  logic clk147 = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  voice_param_writer_if #(.NUM_VOICES(8)) bus ();

  voice_param_writer #(.NUM_VOICES(8)) dut (
    .clk147 (clk147),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk147 = ~clk147;

  // Stand-in for the voice array: each voice latches vc when its select bit is high at an edge
  VC_PARAM voice [8];
  logic    model_en = 1'b0;
  always @(posedge clk147) begin
    for (int v = 0; v < 8; v++) begin
      if (!model_en)                  voice[v] <= '0;
      else if (bus.select[v] === 1'b1) voice[v] <= bus.vc;
    end
  end

  // Commit scoreboard: expected mask queued at COMMIT issue, checked when commit_done appears
  logic [7:0] exp_q [$];
  logic [7:0] prev_sel = '0;
  logic [7:0] exp_m;
  always @(negedge clk147) begin
    if (bus.commit_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_done_unexpected: pulse seen, select before was %0h, none expected", prev_sel);
      end else begin
        exp_m = exp_q.pop_front();
        if (prev_sel !== exp_m) begin
          errors++;
          $display("FAIL commit_select: got %0h expected %0h", prev_sel, exp_m);
        end
      end
    end
    if (bus.select !== 8'h00 && prev_sel !== 8'h00) begin
      checks++;
      errors++;
      $display("FAIL select_width: select %0h high for more than one cycle", bus.select);
    end
    prev_sel = bus.select;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one word, wait for acceptance; returns #1 after the transfer edge
  task automatic put(input logic [6:0] a, input logic [31:0] d, output int waited);
    @(negedge clk147);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    waited = 0;
    while (bus.wr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk147);
      waited++;
    end
    if (waited >= 20) begin
      checks++;
      errors++;
      $display("FAIL put_timeout: wr_ready got %b expected 1 within 20 cycles", bus.wr_ready);
    end
    @(posedge clk147);
    #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk147);
    #1;
  endtask

  function automatic logic [31:0] get_fld(input VC_PARAM p, input logic [3:0] f, input logic [2:0] o);
    logic [31:0] r;
    case (f)
      4'd0:    r = p.freq[o];
      4'd1:    r = p.at_time[o];
      4'd2:    r = p.at_inc[o];
      4'd3:    r = p.de_time[o];
      4'd4:    r = p.de_inc[o];
      4'd5:    r = p.su_time[o];
      4'd6:    r = p.su_lvl[o];
      4'd7:    r = p.re_time[o];
      4'd8:    r = p.re_inc[o];
      4'd9:    r = p.amplitude[o];
      4'd10:   r = (o == 3'd0) ? p.modin_1 : p.modin_2;
      default: r = '0;
    endcase
    return r;
  endfunction

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic        err;   // expected addr_err in the following cycle
    logic [7:0]  cnt;   // expected word_cnt after the transfer
    logic [3:0]  fld;   // image field/op to inspect afterwards
    logic [2:0]  op;
    logic [31:0] val;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] af, input logic [2:0] ao, input logic [31:0] d,
                              input logic e, input logic [7:0] c,
                              input logic [3:0] f, input logic [2:0] o, input logic [31:0] v);
    vec_t r;
    r.addr = {af, ao};
    r.data = d;
    r.err  = e;
    r.cnt  = c;
    r.fld  = f;
    r.op   = o;
    r.val  = v;
    return r;
  endfunction

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    int w;
    vecs[0]  = mk(4'd0,  3'd3, 32'h0040_0000, 1'b0, 8'd1, 4'd0,  3'd3, 32'h0040_0000);
    vecs[1]  = mk(4'd6,  3'd0, 32'h0000_1234, 1'b0, 8'd2, 4'd6,  3'd0, 32'h0000_1234);
    vecs[2]  = mk(4'd9,  3'd5, 32'hA5A5_A5A5, 1'b0, 8'd3, 4'd9,  3'd5, 32'hA5A5_A5A5);
    vecs[3]  = mk(4'd10, 3'd0, 32'h0000_0011, 1'b0, 8'd4, 4'd10, 3'd0, 32'h0000_0011);
    vecs[4]  = mk(4'd10, 3'd1, 32'h0000_0022, 1'b0, 8'd5, 4'd10, 3'd1, 32'h0000_0022);
    vecs[5]  = mk(4'd0,  3'd6, 32'h0000_DEAD, 1'b1, 8'd5, 4'd0,  3'd3, 32'h0040_0000);
    vecs[6]  = mk(4'd12, 3'd0, 32'h0000_BEEF, 1'b1, 8'd5, 4'd10, 3'd0, 32'h0000_0011);
    vecs[7]  = mk(4'd10, 3'd2, 32'h0000_CAFE, 1'b1, 8'd5, 4'd10, 3'd1, 32'h0000_0022);
    vecs[8]  = mk(4'd13, 3'd7, 32'h0000_0001, 1'b1, 8'd5, 4'd9,  3'd5, 32'hA5A5_A5A5);
    vecs[9]  = mk(4'd7,  3'd7, 32'h0000_0BAD, 1'b1, 8'd5, 4'd7,  3'd0, 32'h0000_0000);
    vecs[10] = mk(4'd4,  3'd2, 32'h0000_0077, 1'b0, 8'd6, 4'd4,  3'd2, 32'h0000_0077);

    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    rst_n        = 1'b0;

    // Reset state
    repeat (4) @(posedge clk147);
    @(negedge clk147);
    chk("rst_vc_zero", {31'd0, bus.vc === '0}, 32'd1);
    chk("rst_select", bus.select, 32'h0);
    chk("rst_wr_ready", bus.wr_ready, 32'h0);
    chk("rst_word_cnt", bus.word_cnt, 32'h0);
    chk("rst_commit_done", bus.commit_done, 32'h0);
    chk("rst_addr_err", bus.addr_err, 32'h0);
    model_en = 1'b1;
    rst_n    = 1'b1;
    step();
    chk("rel_wr_ready", bus.wr_ready, 32'h1);

    // Decode / write table
    for (int i = 0; i < NV; i++) begin
      put(vecs[i].addr, vecs[i].data, w);
      chk($sformatf("vec%0d_addr_err", i), bus.addr_err, vecs[i].err);
      chk($sformatf("vec%0d_word_cnt", i), bus.word_cnt, vecs[i].cnt);
      chk($sformatf("vec%0d_field", i), get_fld(bus.vc, vecs[i].fld, vecs[i].op), vecs[i].val);
    end

    // Commit to voices 0 and 2
    exp_q.push_back(8'h05);
    put({4'd15, 3'd0}, 32'h0000_0005, w);
    chk("c1_select", bus.select, 32'h05);
    chk("c1_ready_strobe", bus.wr_ready, 32'h0);
    step();
    chk("c1_select_off", bus.select, 32'h0);
    chk("c1_commit_done", bus.commit_done, 32'h1);
    chk("c1_ready_done", bus.wr_ready, 32'h0);
    step();
    chk("c1_ready_back", bus.wr_ready, 32'h1);
    chk("c1_done_off", bus.commit_done, 32'h0);
    chk("c1_word_cnt", bus.word_cnt, 32'h0);
    chk("c1_v0_freq3", voice[0].freq[3], 32'h0040_0000);
    chk("c1_v2_freq3", voice[2].freq[3], 32'h0040_0000);
    chk("c1_v1_freq3", voice[1].freq[3], 32'h0);

    // Back-pressure: a write held right behind a COMMIT waits out STROBE and DONE
    exp_q.push_back(8'h02);
    put({4'd15, 3'd4}, 32'h0000_0002, w);
    put({4'd6, 3'd0}, 32'h0000_9999, w);
    chk("bp_wait_cycles", w, 32'd2);
    chk("bp_img_sulvl0", bus.vc.su_lvl[0], 32'h0000_9999);
    chk("bp_v1_sulvl0", voice[1].su_lvl[0], 32'h0000_1234);
    chk("bp_word_cnt", bus.word_cnt, 32'h1);

    // Saturation and empty-mask commit (upper data bits must not leak into the mask)
    for (int i = 0; i < 300; i++) put({4'd1, 3'(i % 6)}, 32'(i), w);
    chk("sat_word_cnt", bus.word_cnt, 32'd255);
    exp_q.push_back(8'h00);
    put({4'd15, 3'd0}, 32'hFFFF_FF00, w);
    chk("m0_select", bus.select, 32'h0);
    step();
    chk("m0_commit_done", bus.commit_done, 32'h1);
    step();
    chk("m0_word_cnt", bus.word_cnt, 32'h0);

    // Reset during STROBE aborts the commit
    put({4'd15, 3'd0}, 32'h0000_00FF, w);
    chk("ra_select", bus.select, 32'hFF);
    @(negedge clk147);
    rst_n = 1'b0;
    step();
    chk("ra_select_off", bus.select, 32'h0);
    chk("ra_ready", bus.wr_ready, 32'h0);
    step();
    chk("ra_no_done", bus.commit_done, 32'h0);
    @(negedge clk147);
    rst_n = 1'b1;
    step();
    chk("ra_ready_back", bus.wr_ready, 32'h1);

    // CLEAR then commit all voices: every voice holds an all-zero image
    put({4'd0, 3'd0}, 32'h0000_0055, w);
    put({4'd10, 3'd0}, 32'h0000_0066, w);
    put({4'd14, 3'd3}, 32'h1234_5678, w);
    chk("clr_img_zero", {31'd0, bus.vc === '0}, 32'd1);
    chk("clr_word_cnt", bus.word_cnt, 32'h0);
    exp_q.push_back(8'hFF);
    put({4'd15, 3'd0}, 32'h0000_00FF, w);
    step();
    step();
    for (int v = 0; v < 8; v++)
      chk($sformatf("clr_voice%0d_zero", v), {31'd0, voice[v] === '0}, 32'd1);

    // A write directly after CLEAR lands on the cleared image
    put({4'd0, 3'd0}, 32'h0000_0055, w);
    put({4'd14, 3'd0}, 32'h0, w);
    put({4'd9, 3'd1}, 32'h0000_0007, w);
    chk("cw_freq0", bus.vc.freq[0], 32'h0);
    chk("cw_amp1", bus.vc.amplitude[1], 32'h7);
    chk("cw_word_cnt", bus.word_cnt, 32'h1);

    repeat (3) step();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: simulation did not complete within time budget");
    $fatal(1);
  end

endmodule
